nrzi_stuff_enc: RTL and testbench
=================================

Name: nrzi_stuff_enc

Overview:
Parametrised serial line encoder combining bit stuffing and NRZI. It accepts a packet bit stream over a valid/ready handshake. After RUN_LEN consecutive 1s it inserts a stuffed 0 and stalls the source while doing so. It outputs the NRZI line level with a bit-cell strobe and returns the line to a configurable idle level between packets. It sits between the packet serialiser and the line driver and replaces the fixed single-bit NRZI stage.

Parameters:
RUN_LEN, 6, count of consecutive 1s after which one 0 is stuffed; legal range 1 to 15.
IDLE_LEVEL, 1'b1, line level driven in idle; also the NRZI reference level for the first bit of a packet.
CNT_W, $clog2(RUN_LEN+1), width of the ones-run counter; derived, never overridden.

Ports:
clk  input  1  system clock
rst_L  input  1  asynchronous active-low reset
in_valid  input  1  in_bit/in_last are valid this cycle
in_bit  input  1  raw (unstuffed, un-encoded) data bit
in_last  input  1  the current bit is the final bit of the packet
in_ready  output  1  encoder accepts a bit this cycle
abort  input  1  synchronous packet abort
out_bit  output  1  NRZI line level (registered)
out_en  output  1  out_bit carries a new bit cell this cycle (registered)
stuffed  output  1  the current cell is a stuffed bit (registered)
busy  output  1  state is not IDLE

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_L.
- Reset values: state IDLE, out_bit=IDLE_LEVEL, out_en=0, stuffed=0, run count=0, pend_last=0.
- States:
  - IDLE: no packet in flight.
  - SEND: packet in flight, data cells.
  - STUFF: inserting one stuffed cell.
- Accept: a bit is accepted when in_valid && in_ready. in_ready = !abort && state!=STUFF.
- Encoding reference: ref = IDLE_LEVEL in IDLE, otherwise the current out_bit.
- For an accepted bit, at the next edge:
  - in_bit=0: out_bit <= ~ref, run count <= 0.
  - in_bit=1: out_bit <= ref, run count <= count+1.
  - In both cases out_en <= 1 and stuffed <= 0.
- Latency: the cell appears one cycle after acceptance.
- Next state after an accepted bit:
  - new count == RUN_LEN: go to STUFF, with pend_last <= in_last.
  - else if in_last: go to IDLE.
  - else: go to SEND. IDLE also accepts bits and goes to SEND or STUFF.
- STUFF, one cycle with in_ready=0. At the next edge:
  - out_bit <= ~out_bit, out_en <= 1, stuffed <= 1, count <= 0.
  - Next state is IDLE if pend_last, else SEND.
- A stuff is emitted even when the run completes on the last bit.
- SEND with no accept (gap):
  - out_en <= 0, stuffed <= 0.
  - out_bit and count hold, so the run continues across gaps.
- IDLE with no accept: out_bit <= IDLE_LEVEL, out_en <= 0, count <= 0.
- Back-to-back packets: a bit accepted in the first IDLE cycle after a last bit encodes against IDLE_LEVEL. The line shows no idle cell in between.
- abort (highest priority over accept and stuff) causes at the next edge:
  - state IDLE.
  - out_bit <= IDLE_LEVEL, out_en <= 0, stuffed <= 0.
  - count <= 0, pend_last <= 0.
  - Any pending stuff is dropped and no bit is accepted that cycle.
- rst_L asserted mid-packet: immediate return to reset values; no partial cell.
- Count arithmetic: CNT_W bits unsigned; never exceeds RUN_LEN.
- RUN_LEN=1: every 1 is followed by a stuff cell.

Decomposition:
- Shared package nrzi_pkg holds:
  - the enc_state_t enum (IDLE, SEND, STUFF);
  - constants DEF_RUN_LEN=6 and DEF_IDLE_LEVEL=1'b1, for reuse by the matching decoder/destuffer.
- The line-level and flag flops use the existing register#(W) building block.
- One natural sub-module: run_counter#(CNT_W), providing clear, increment, and a hit flag (count == RUN_LEN).

Test Plan:
1. Reset (rst_L low mid-stream, then release) -> out_bit=1, out_en=0, stuffed=0, in_ready=1, busy=0 immediately on assertion.
2. Packet 0,0,1,0 (last on 4th), RUN_LEN=6 -> out_bit cells 0,1,1,0 with out_en=1 for 4 cycles, then out_bit=1, out_en=0, busy=0.
3. Eight 1s then last -> first six cells at level 1, seventh cell 0 with stuffed=1, in_ready=0 for exactly that stuff cycle, remaining two 1s at level 0.
4. Six 1s with in_last on the 6th -> six cells at 1, stuff cell 0 (stuffed=1), then idle with out_bit=1; a new packet in the following cycle encodes against IDLE_LEVEL.
5. Three 1s, in_valid low 2 cycles, three 1s -> out_en=0 and out_bit held during the gap; stuff inserted after the 6th 1.
6. abort asserted in a STUFF cycle -> next edge out_bit=1, out_en=0, stuffed=0, busy=0, in_ready low during abort; repeat with RUN_LEN=1: input 1,1 -> cells 1,0(stuff),0,1(stuff).

Source files
------------

// File: rtl/nrzi_pkg.sv
// Shared definitions for the bit-stuffing NRZI encoder and its matching
// decoder/destuffer: FSM state type, default line parameters, debug view.
package nrzi_pkg;

  localparam int unsigned DEF_RUN_LEN    = 6;
  localparam logic        DEF_IDLE_LEVEL = 1'b1;

  // Debug count field is sized for the largest legal run length (15).
  localparam int unsigned DBG_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } enc_state_t;

  typedef struct packed {
    enc_state_t           state;
    logic [DBG_CNT_W-1:0] count;
    logic                 hit;
    logic                 pend_last;
  } enc_dbg_t;

endpackage

// File: rtl/register.sv
// Plain W-bit register with asynchronous active-low reset to RST_VAL.
module register #(
  parameter int unsigned    W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d every cycle; reset forces RST_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/run_counter.sv
// Counter of consecutive 1s in the outgoing data stream.
// clr and inc together restart the run at 1 (first bit of a new packet is a 1).
module run_counter #(
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned RUN_LEN = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  // Clear, restart-at-one, increment or hold the run length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count <= '0;
    else if (clr && inc) count <= CNT_W'(1);
    else if (clr)        count <= '0;
    else if (inc)        count <= count + CNT_W'(1);
  end

  assign hit = (count == CNT_W'(RUN_LEN));

endmodule

// File: rtl/nrzi_stuff_enc.sv
// Bit-stuffing NRZI line encoder.
// Handshake: a bit transfers on a cycle where in_valid && in_ready are both
// high; in_ready depends only on abort and the current state, never on
// in_valid, and the encoded cell appears on the line one cycle later.
module nrzi_stuff_enc
  import nrzi_pkg::*;
#(
  parameter int unsigned RUN_LEN    = DEF_RUN_LEN,
  parameter logic        IDLE_LEVEL = DEF_IDLE_LEVEL,
  parameter int unsigned CNT_W      = $clog2(RUN_LEN + 1)
) (
  input  logic     clk,
  input  logic     rst_L,
  input  logic     in_valid,
  input  logic     in_bit,
  input  logic     in_last,
  output logic     in_ready,
  input  logic     abort,
  output logic     out_bit,
  output logic     out_en,
  output logic     stuffed,
  output logic     busy,
  output enc_dbg_t dbg
);

  localparam logic [CNT_W:0] RUN_LEN_X = (CNT_W + 1)'(RUN_LEN);
  localparam logic [CNT_W:0] ONE_X     = (CNT_W + 1)'(1);

  enc_state_t       state, state_nxt;
  logic             accept;
  logic             ref_level;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] base_cnt;
  logic             run_hit_nxt;
  logic             cnt_clr, cnt_inc, cnt_hit;
  logic             out_bit_d, out_en_d, stuffed_d;
  logic             pend_last, pend_last_d;

  assign in_ready = !abort && (state != STUFF);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // A new packet encodes against the idle level and starts a fresh run.
  assign ref_level   = (state == IDLE) ? IDLE_LEVEL : out_bit;
  assign base_cnt    = (state == IDLE) ? '0 : cnt;
  assign run_hit_nxt = in_bit && (({1'b0, base_cnt} + ONE_X) == RUN_LEN_X);

  run_counter #(
    .CNT_W  (CNT_W),
    .RUN_LEN(RUN_LEN)
  ) u_run (
    .clk  (clk),
    .rst_n(rst_L),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .count(cnt),
    .hit  (cnt_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: abort wins, a stuff cell lasts one cycle, accepted bits steer.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else if (state == STUFF) begin
      state_nxt = pend_last ? IDLE : SEND;
    end else if (accept) begin
      if (run_hit_nxt)  state_nxt = STUFF;
      else if (in_last) state_nxt = IDLE;
      else              state_nxt = SEND;
    end else if (state == IDLE) begin
      state_nxt = IDLE;
    end else begin
      state_nxt = SEND;
    end
  end

  // Outputs: next line level, cell flags and run-counter control.
  always_comb begin
    out_bit_d   = out_bit;
    out_en_d    = 1'b0;
    stuffed_d   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    pend_last_d = pend_last;
    if (abort) begin
      out_bit_d   = IDLE_LEVEL;
      cnt_clr     = 1'b1;
      pend_last_d = 1'b0;
    end else if (state == STUFF) begin
      out_bit_d = ~out_bit;
      out_en_d  = 1'b1;
      stuffed_d = 1'b1;
      cnt_clr   = 1'b1;
    end else if (accept) begin
      out_en_d = 1'b1;
      if (in_bit) begin
        out_bit_d = ref_level;
        cnt_inc   = 1'b1;
        cnt_clr   = (state == IDLE);
      end else begin
        out_bit_d = ~ref_level;
        cnt_clr   = 1'b1;
      end
      if (run_hit_nxt) pend_last_d = in_last;
    end else if (state == IDLE) begin
      out_bit_d = IDLE_LEVEL;
      cnt_clr   = 1'b1;
    end
  end

  register #(.W(1), .RST_VAL(IDLE_LEVEL)) u_out_bit (
    .clk(clk), .rst_n(rst_L), .d(out_bit_d), .q(out_bit)
  );
  register #(.W(1), .RST_VAL(1'b0)) u_out_en (
    .clk(clk), .rst_n(rst_L), .d(out_en_d), .q(out_en)
  );
  register #(.W(1), .RST_VAL(1'b0)) u_stuffed (
    .clk(clk), .rst_n(rst_L), .d(stuffed_d), .q(stuffed)
  );
  register #(.W(1), .RST_VAL(1'b0)) u_pend_last (
    .clk(clk), .rst_n(rst_L), .d(pend_last_d), .q(pend_last)
  );

  assign dbg.state     = state;
  assign dbg.count     = DBG_CNT_W'(cnt);
  assign dbg.hit       = cnt_hit;
  assign dbg.pend_last = pend_last;

endmodule

// File: tb/tb_nrzi_stuff_enc.sv
// Bench for nrzi_stuff_enc: one instance with RUN_LEN=6, one with RUN_LEN=1,
// each with its own inputs. A rule-level line model is checked every cycle,
// and recorded cells are compared against hand-computed expected queues.
module tb_nrzi_stuff_enc;
  import nrzi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_L = 1'b0;
  always #5 clk = ~clk;

  logic iv[2], ib[2], il[2], ab[2];
  logic rdy[2], ob[2], oe[2], os[2], bz[2];
  enc_dbg_t dbg0, dbg1;

  nrzi_stuff_enc #(.RUN_LEN(6), .IDLE_LEVEL(1'b1)) dut6 (
    .clk(clk), .rst_L(rst_L), .in_valid(iv[0]), .in_bit(ib[0]), .in_last(il[0]),
    .in_ready(rdy[0]), .abort(ab[0]), .out_bit(ob[0]), .out_en(oe[0]),
    .stuffed(os[0]), .busy(bz[0]), .dbg(dbg0)
  );

  nrzi_stuff_enc #(.RUN_LEN(1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst_L(rst_L), .in_valid(iv[1]), .in_bit(ib[1]), .in_last(il[1]),
    .in_ready(rdy[1]), .abort(ab[1]), .out_bit(ob[1]), .out_en(oe[1]),
    .stuffed(os[1]), .busy(bz[1]), .dbg(dbg1)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int stalls  = 0;
  logic [1:0] exp_q[$];   // expected cells {stuffed, level}
  logic [1:0] cells0[$];
  logic [1:0] cells1[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- line model ----------------
  // Tracks the line level, the length of the current 1s run, whether a packet
  // is open, and whether a stuff cell is owed.
  int   run_len[2] = '{6, 1};
  int   m_ones[2];
  logic m_level[2], m_en[2], m_st[2], m_pkt[2], m_due[2], m_close[2];

  function automatic void model_reset(input int k);
    m_ones[k] = 0; m_level[k] = 1'b1; m_en[k] = 1'b0; m_st[k] = 1'b0;
    m_pkt[k] = 1'b0; m_due[k] = 1'b0; m_close[k] = 1'b0;
  endfunction

  function automatic void model_step(input int k);
    logic ready, refl;
    ready = !ab[k] && !m_due[k];
    if (ab[k]) begin
      model_reset(k);
    end else if (m_due[k]) begin
      m_level[k] = ~m_level[k]; m_en[k] = 1'b1; m_st[k] = 1'b1;
      m_ones[k] = 0; m_due[k] = 1'b0; m_pkt[k] = !m_close[k];
    end else if (iv[k] && ready) begin
      refl = m_pkt[k] ? m_level[k] : 1'b1;
      if (!m_pkt[k]) m_ones[k] = 0;
      if (ib[k]) begin m_level[k] = refl;  m_ones[k] = m_ones[k] + 1; end
      else       begin m_level[k] = ~refl; m_ones[k] = 0; end
      m_en[k] = 1'b1; m_st[k] = 1'b0;
      if (m_ones[k] == run_len[k]) begin
        m_due[k] = 1'b1; m_close[k] = il[k]; m_pkt[k] = 1'b1;
      end else begin
        m_pkt[k] = !il[k];
      end
    end else if (m_pkt[k]) begin
      m_en[k] = 1'b0; m_st[k] = 1'b0;
    end else begin
      m_level[k] = 1'b1; m_en[k] = 1'b0; m_st[k] = 1'b0; m_ones[k] = 0;
    end
  endfunction

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or negedge rst_L);
      for (int k = 0; k < 2; k++) begin
        if (!rst_L) model_reset(k);
        else        model_step(k);
      end
    end
  end

  // Per-cycle compare and cell recording, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_L) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("d%0d_in_ready", k), 32'(rdy[k]), 32'(!ab[k] && !m_due[k]));
          check($sformatf("d%0d_out_bit", k),  32'(ob[k]),  32'(m_level[k]));
          check($sformatf("d%0d_out_en", k),   32'(oe[k]),  32'(m_en[k]));
          check($sformatf("d%0d_stuffed", k),  32'(os[k]),  32'(m_st[k]));
          check($sformatf("d%0d_busy", k),     32'(bz[k]),  32'(m_pkt[k] || m_due[k]));
        end
        if (oe[0]) cells0.push_back({os[0], ob[0]});
        if (oe[1]) cells1.push_back({os[1], ob[1]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input int k, input logic b, input logic last);
    int n;
    iv[k] = 1'b1; ib[k] = b; il[k] = last; n = 0;
    forever begin
      @(negedge clk);
      if (rdy[k]) break;
      stalls++;
      n++;
      if (n > 20) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: dut %0d never ready", k);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    iv[k] = 1'b0; ib[k] = 1'b0; il[k] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_n(input int n, input logic st, input logic lvl);
    repeat (n) exp_q.push_back({st, lvl});
  endtask

  task automatic start_test();
    exp_q.delete(); cells0.delete(); cells1.delete(); stalls = 0;
  endtask

  task automatic check_cells(input string name, input int k);
    int got;
    got = (k == 0) ? cells0.size() : cells1.size();
    check({name, "_cell_count"}, 32'(got), 32'(exp_q.size()));
    for (int i = 0; i < got && i < exp_q.size(); i++)
      check($sformatf("%s_cell%0d", name, i),
            32'((k == 0) ? cells0[i] : cells1[i]), 32'(exp_q[i]));
  endtask

  task automatic check_idle(input string name, input int k);
    check({name, "_idle_out_bit"}, 32'(ob[k]), 32'd1);
    check({name, "_idle_out_en"},  32'(oe[k]), 32'd0);
    check({name, "_idle_busy"},    32'(bz[k]), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ib[k] = 1'b0; il[k] = 1'b0; ab[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2 rst_L = 1'b1;
    @(negedge clk);
    check("rst_out_bit", 32'(ob[0]), 32'd1);
    check("rst_out_en",  32'(oe[0]), 32'd0);
    check("rst_ready",   32'(rdy[0]), 32'd1);
    check("rst_state",   32'(dbg0.state), 32'(IDLE));
    @(posedge clk); #1;

    // Packet 0,0,1,0 -> cells 0,1,1,0
    start_test();
    send(0, 1'b0, 1'b0); send(0, 1'b0, 1'b0); send(0, 1'b1, 1'b0); send(0, 1'b0, 1'b1);
    idle_cycles(1);
    push_n(1, 0, 0); push_n(2, 0, 1); push_n(1, 0, 0);
    check_cells("t2", 0);
    check_idle("t2", 0);

    // Eight 1s, last on the 8th: six at 1, stuff 0, two at 0
    start_test();
    for (int i = 0; i < 8; i++) send(0, 1'b1, i == 7);
    idle_cycles(2);
    push_n(6, 0, 1); push_n(1, 1, 0); push_n(2, 0, 0);
    check_cells("t3", 0);
    check("t3_stall_cycles", 32'(stalls), 32'd1);
    check_idle("t3", 0);

    // Six 1s ending the packet, then a 1-bit packet right behind it
    start_test();
    for (int i = 0; i < 6; i++) send(0, 1'b1, i == 5);
    send(0, 1'b1, 1'b1);
    idle_cycles(2);
    push_n(6, 0, 1); push_n(1, 1, 0); push_n(1, 0, 1);
    check_cells("t4", 0);
    check_idle("t4", 0);

    // Three 1s, two-cycle gap, three 1s, then a final 0
    start_test();
    for (int i = 0; i < 3; i++) send(0, 1'b1, 1'b0);
    idle_cycles(1);
    check("t5_gap_out_en",  32'(oe[0]), 32'd0);
    check("t5_gap_out_bit", 32'(ob[0]), 32'd1);
    check("t5_gap_busy",    32'(bz[0]), 32'd1);
    idle_cycles(1);
    for (int i = 0; i < 3; i++) send(0, 1'b1, 1'b0);
    send(0, 1'b0, 1'b1);
    idle_cycles(2);
    push_n(6, 0, 1); push_n(1, 1, 0); push_n(1, 0, 1);
    check_cells("t5", 0);
    check_idle("t5", 0);

    // Abort during the stuff cycle drops the stuff cell
    start_test();
    for (int i = 0; i < 6; i++) send(0, 1'b1, 1'b0);
    ab[0] = 1'b1;
    @(negedge clk);
    check("t6_abort_ready", 32'(rdy[0]), 32'd0);
    @(posedge clk); #1;
    ab[0] = 1'b0;
    check("t6_abort_stuffed", 32'(os[0]), 32'd0);
    check_idle("t6_abort", 0);
    idle_cycles(2);
    push_n(6, 0, 1);
    check_cells("t6", 0);

    // RUN_LEN=1: input 1,1 -> 1, 0(stuff), 0, 1(stuff)
    start_test();
    send(1, 1'b1, 1'b0); send(1, 1'b1, 1'b1);
    idle_cycles(3);
    push_n(1, 0, 1); push_n(1, 1, 0); push_n(1, 0, 0); push_n(1, 1, 1);
    check_cells("t6b", 1);
    check_idle("t6b", 1);

    // Reset asserted mid-packet returns outputs at once
    iv[0] = 1'b1; ib[0] = 1'b1; il[0] = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_L = 1'b0;
    #1;
    check("t1_rst_out_bit", 32'(ob[0]),  32'd1);
    check("t1_rst_out_en",  32'(oe[0]),  32'd0);
    check("t1_rst_stuffed", 32'(os[0]),  32'd0);
    check("t1_rst_ready",   32'(rdy[0]), 32'd1);
    check("t1_rst_busy",    32'(bz[0]),  32'd0);
    check("t1_rst_count",   32'(dbg0.count), 32'd0);
    iv[0] = 1'b0; ib[0] = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_L = 1'b1;
    @(posedge clk); #1;
    start_test();
    send(0, 1'b0, 1'b1);
    idle_cycles(1);
    push_n(1, 0, 0);
    check_cells("t1_after", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
